// File: rtl/ddfs_tw_loader_if.sv
// Byte-side handshake and tuning-word latch signals of the DDFS tuning-word loader.
// master = byte source / latch side, slave = loader.
interface ddfs_tw_loader_if;
    logic [7:0]  Byte_In;
    logic        Byte_Valid;
    logic        Byte_Ready;
    logic        Abort;
    logic [47:0] Word_Out;
    logic        Load_EN;
    logic        Busy;
    logic        Err;

    modport master (
        output Byte_In, Byte_Valid, Abort,
        input  Byte_Ready, Word_Out, Load_EN, Busy, Err
    );

    modport slave (
        input  Byte_In, Byte_Valid, Abort,
        output Byte_Ready, Word_Out, Load_EN, Busy, Err
    );
endinterface

// File: rtl/ddfs_tw_loader.sv
// Byte-serial loader for the 48-bit DDFS tuning-word latch: assembles a frame and pulses Load_EN.
// Optional macro DDFS_LD_CKSUM_EN appends an XOR checksum byte and a one-cycle CHECK state.
//
// state     | meaning
// S_IDLE    | waiting for byte 0 of a frame, Byte_Ready=1
// S_COLLECT | gathering bytes 1..N-1, idle timer running
// S_CHECK   | (checksum build only) compare XOR of data bytes against the checksum byte
// S_LOAD    | Load_EN=1 for exactly one cycle, Byte_Ready=0
module ddfs_tw_loader #(
    parameter int TIMEOUT_CYC = 1023,
    parameter bit MSB_FIRST   = 1'b1
) (
    input logic           Clock,
    input logic           Reset,
    ddfs_tw_loader_if.slave bus
);

`ifdef DDFS_LD_CKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_LOAD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_LOAD} state_t;
`endif

    localparam int          TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  LAST_DATA = 3'd5;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [47:0]   shift_q, shift_d;
    logic [47:0]   word_q, word_d;
    logic          load_en_q, load_en_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          byte_ready_q, byte_ready_d;
`ifdef DDFS_LD_CKSUM_EN
    logic [7:0]    xor_q, xor_d;
    logic [7:0]    cks_q, cks_d;
`endif

    logic          accept;
    logic [47:0]   shifted;

    assign accept  = bus.Byte_Valid & byte_ready_q;
    // Shifting in from one end lands byte 0 in the top or bottom lane after six bytes.
    assign shifted = MSB_FIRST ? {shift_q[39:0], bus.Byte_In} : {bus.Byte_In, shift_q[47:8]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        shift_d   = shift_q;
        word_d    = word_q;
        load_en_d = 1'b0;
        err_d     = err_q;
`ifdef DDFS_LD_CKSUM_EN
        xor_d     = xor_q;
        cks_d     = cks_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept && !bus.Abort) begin
                    shift_d = shifted;
                    cnt_d   = 3'd1;
                    tmr_d   = TMR_LOAD;
                    err_d   = 1'b0;
                    state_d = S_COLLECT;
`ifdef DDFS_LD_CKSUM_EN
                    xor_d   = bus.Byte_In;
`endif
                end
            end
            S_COLLECT: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    tmr_d = TMR_LOAD;
                    cnt_d = cnt_q + 3'd1;
`ifdef DDFS_LD_CKSUM_EN
                    if (cnt_q == LAST_DATA + 3'd1) begin
                        cks_d   = bus.Byte_In;
                        state_d = S_CHECK;
                    end else begin
                        shift_d = shifted;
                        xor_d   = xor_q ^ bus.Byte_In;
                    end
`else
                    if (cnt_q == LAST_DATA) begin
                        word_d    = shifted;
                        load_en_d = 1'b1;
                        state_d   = S_LOAD;
                    end else begin
                        shift_d = shifted;
                    end
`endif
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
`ifdef DDFS_LD_CKSUM_EN
            S_CHECK: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (xor_q == cks_q) begin
                    word_d    = shift_q;
                    load_en_d = 1'b1;
                    state_d   = S_LOAD;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            S_LOAD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        byte_ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tmr_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            load_en_q    <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            byte_ready_q <= 1'b0;
`ifdef DDFS_LD_CKSUM_EN
            xor_q        <= '0;
            cks_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            load_en_q    <= load_en_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            byte_ready_q <= byte_ready_d;
`ifdef DDFS_LD_CKSUM_EN
            xor_q        <= xor_d;
            cks_q        <= cks_d;
`endif
        end
    end

    assign bus.Byte_Ready = byte_ready_q;
    assign bus.Word_Out   = word_q;
    assign bus.Load_EN    = load_en_q;
    assign bus.Busy       = busy_q;
    assign bus.Err        = err_q;

endmodule

// File: tb/tb_ddfs_tw_loader.sv
// Self-checking bench for ddfs_tw_loader (default 6-byte frame, MSB first, short timeout).
// Table vectors, directed corner sequences and a randomized run against a frame-level model.
module tb_ddfs_tw_loader;
    localparam int T = 20;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    ddfs_tw_loader_if bus_if();

    ddfs_tw_loader #(.TIMEOUT_CYC(T), .MSB_FIRST(1'b1)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_if.slave)
    );

    typedef struct {
        bit          v;
        logic [7:0]  b;
        bit          a;
        bit          rdy;
        bit          ld;
        bit          bsy;
        bit          err;
        logic [47:0] word;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    int n_loads = 0;

    // reference model: frame-level view (bytes collected so far, idle gap length)
    bit          m_ready, m_busy, m_err, m_load, m_loading;
    logic [47:0] m_word;
    logic [7:0]  q[$];
    int          gap;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready = 0; m_busy = 0; m_err = 0; m_load = 0; m_loading = 0;
        m_word = '0; gap = 0;
        q.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit a);
        bit acc;
        logic [47:0] w;
        acc = v && m_ready;
        m_load = 0;
        if (m_loading) begin
            m_loading = 0; m_ready = 1; m_busy = 0;
        end else if (q.size() == 0) begin
            m_ready = 1;
            if (acc && !a) begin
                q.push_back(b); gap = 0; m_err = 0; m_busy = 1;
            end
        end else if (a) begin
            q.delete(); m_busy = 0;
        end else if (acc) begin
            q.push_back(b); gap = 0;
            if (q.size() == 6) begin
                w = '0;
                foreach (q[i]) w = w * 48'd256 + 48'(q[i]);
                m_word = w; m_load = 1; m_loading = 1; m_ready = 0;
                q.delete();
            end
        end else begin
            gap++;
            if (gap >= T) begin
                m_err = 1; m_busy = 0; q.delete();
            end
        end
    endtask

    task automatic check_model();
        chk("ready", 48'(bus_if.Byte_Ready), 48'(m_ready));
        chk("load",  48'(bus_if.Load_EN),    48'(m_load));
        chk("busy",  48'(bus_if.Busy),       48'(m_busy));
        chk("err",   48'(bus_if.Err),        48'(m_err));
        chk("word",  bus_if.Word_Out,        m_word);
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit a);
        bus_if.Byte_Valid = v;
        bus_if.Byte_In    = b;
        bus_if.Abort      = a;
        @(posedge Clock);
        model_step(v, b, a);
        #1;
        if (bus_if.Load_EN) n_loads++;
        check_model();
    endtask

    task automatic send_frame(input logic [47:0] w, input int gap_cyc);
        logic [47:0] t;
        t = w;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, t[47:40], 1'b0);
            t = t << 8;
            if (i < 5) repeat (gap_cyc) cycle(1'b0, 8'h00, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    vec_t tbl[10];

    initial begin
        int l0;
        bit rv, ra, hold;
        logic [7:0] rb;
        int idle_left;

        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0};
        tbl[1] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 48'h0};
        tbl[2] = '{1'b1, 8'h23, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 48'h0};
        tbl[3] = '{1'b1, 8'h45, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 48'h0};
        tbl[4] = '{1'b1, 8'h67, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 48'h0};
        tbl[5] = '{1'b1, 8'h89, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 48'h0};
        tbl[6] = '{1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h0123_4567_89AB};
        tbl[7] = '{1'b1, 8'hCD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0123_4567_89AB};
        tbl[8] = '{1'b1, 8'hCD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0123_4567_89AB};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0123_4567_89AB};

        bus_if.Byte_Valid = 1'b0;
        bus_if.Byte_In    = 8'h00;
        bus_if.Abort      = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_model();
        Reset = 1'b1;

        // basic back-to-back load, Abort in IDLE, table expectations
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].a);
            chk($sformatf("tbl%0d_rdy", i),  48'(bus_if.Byte_Ready), 48'(tbl[i].rdy));
            chk($sformatf("tbl%0d_ld", i),   48'(bus_if.Load_EN),    48'(tbl[i].ld));
            chk($sformatf("tbl%0d_busy", i), 48'(bus_if.Busy),       48'(tbl[i].bsy));
            chk($sformatf("tbl%0d_err", i),  48'(bus_if.Err),        48'(tbl[i].err));
            chk($sformatf("tbl%0d_word", i), bus_if.Word_Out,        tbl[i].word);
        end

        // asynchronous reset in the middle of a frame
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        bus_if.Byte_Valid = 1'b0;
        Reset = 1'b0;
        #2;
        model_reset();
        chk("rst_word", bus_if.Word_Out, 48'h0);
        chk("rst_load", 48'(bus_if.Load_EN), 48'h0);
        chk("rst_err",  48'(bus_if.Err), 48'h0);
        chk("rst_busy", 48'(bus_if.Busy), 48'h0);
        chk("rst_rdy",  48'(bus_if.Byte_Ready), 48'h0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        chk("rst_rdy_rise", 48'(bus_if.Byte_Ready), 48'h1);
        send_frame(48'hAABB_CCDD_EEFF, 0);
        chk("rst_frame_word", bus_if.Word_Out, 48'hAABB_CCDD_EEFF);

        // gaps of T-1 idle cycles between bytes still load
        l0 = n_loads;
        send_frame(48'h1357_9BDF_2468, T - 1);
        chk("gap_loads", 48'(n_loads - l0), 48'd1);
        chk("gap_word", bus_if.Word_Out, 48'h1357_9BDF_2468);
        chk("gap_err", 48'(bus_if.Err), 48'h0);

        // timeout after two bytes and T idle cycles
        l0 = n_loads;
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0);
        repeat (T - 1) cycle(1'b0, 8'h00, 1'b0);
        chk("to_edge_err", 48'(bus_if.Err), 48'h0);
        chk("to_edge_busy", 48'(bus_if.Busy), 48'h1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("to_err", 48'(bus_if.Err), 48'h1);
        chk("to_busy", 48'(bus_if.Busy), 48'h0);
        chk("to_loads", 48'(n_loads - l0), 48'd0);
        chk("to_word_hold", bus_if.Word_Out, 48'h1357_9BDF_2468);
        cycle(1'b1, 8'h77, 1'b0);
        chk("to_err_clr", 48'(bus_if.Err), 48'h0);
        repeat (5) cycle(1'b1, 8'h88, 1'b0);
        chk("to_next_word", bus_if.Word_Out, 48'h7788_8888_8888);
        cycle(1'b0, 8'h00, 1'b0);

        // Abort together with the sixth byte
        l0 = n_loads;
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        cycle(1'b1, 8'h15, 1'b1);
        chk("ab_load", 48'(bus_if.Load_EN), 48'h0);
        chk("ab_busy", 48'(bus_if.Busy), 48'h0);
        chk("ab_err", 48'(bus_if.Err), 48'h0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("ab_loads", 48'(n_loads - l0), 48'd0);
        send_frame(48'hFEDC_BA98_7654, 0);
        chk("ab_next_word", bus_if.Word_Out, 48'hFEDC_BA98_7654);

        // randomized traffic with idle stretches and occasional Abort
        hold = 1'b0;
        rb = 8'h00;
        idle_left = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!hold) rb = 8'($urandom);
            if (idle_left > 0) begin
                rv = 1'b0;
                idle_left--;
            end else begin
                rv = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 29) == 0) idle_left = $urandom_range(T - 3, T + 3);
            end
            ra = ($urandom_range(0, 49) == 0);
            hold = rv && !m_ready && !ra;
            cycle(rv, rb, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
